elastic_pipe_reg: RTL

- Generic, parametrised pipeline stage register. Successor to the fixed per-stage latch interfaces (e.g. MEM/WB).
- Carries an opaque packed payload between two pipeline stages using a valid/ready handshake.
- Optional two-entry skid buffer, synchronous flush with optional bubble zeroing, and a saturating stall-cycle counter.
- Instantiated between every stage pair (IF/ID, ID/EX, EX/MEM, MEM/WB); the stage interfaces pack their fields into data_in/data_out.

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/elastic_pipe_reg.sv | 136 +++++++++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: stage-register occupancy states and the packed
// payload widths of each inter-stage interface.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pstage_t;

  // pc (32) + instr (32)
  localparam int IFID_W  = 64;
  // pc + rs1/rs2 data + imm (128) + rd (5) + 16 control bits
  localparam int IDEX_W  = 149;
  // pcplus4 + aluOut + store data (96) + rd (5) + 8 control bits
  localparam int EXMEM_W = 109;
  // pcplus4 + aluOut + dmemload (96) + 6 control bits
  localparam int MEMWB_W = 102;

endpackage

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline stage register: valid/ready handshake, optional two-entry
// skid buffer, synchronous flush and a saturating stall-cycle counter.
module elastic_pipe_reg
  import cpu_types_pkg::*;
#(
  parameter int WIDTH          = MEMWB_W,
  parameter int SKID           = 1,
  parameter int CLEAR_ON_FLUSH = 1,
  parameter int CNT_W          = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  pstage_t          state_q, state_d;
  logic             in_xfer, out_xfer;
  logic             load_main, main_from_skid, load_skid, clear;
  logic [WIDTH-1:0] main_q, skid_data;
  logic [CNT_W-1:0] stall_q;

  assign out_valid = (state_q != PS_EMPTY);
  assign data_out  = main_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    clear          = flush && (CLEAR_ON_FLUSH != 0);
    if (flush) begin
      state_d = PS_EMPTY;
    end else begin
      unique case (state_q)
        PS_EMPTY: if (in_xfer) begin
          state_d   = PS_ONE;
          load_main = 1'b1;
        end
        PS_ONE: begin
          if (in_xfer && out_xfer) begin
            load_main = 1'b1;
          end else if (in_xfer && (SKID != 0)) begin
            state_d   = PS_TWO;
            load_skid = 1'b1;
          end else if (out_xfer) begin
            state_d = PS_EMPTY;
          end
        end
        PS_TWO: if (out_xfer) begin
          state_d        = PS_ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= PS_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: payload registers are reset so data_out reads zero out of reset;
  // after that they change only on a load or a clearing flush.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      main_q <= '0;
    end else if (clear) begin
      main_q <= '0;
    end else if (load_main) begin
      main_q <= main_from_skid ? skid_data : data_in;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [WIDTH-1:0] skid_q;
      logic             in_ready_q;

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          skid_q <= '0;
        end else if (clear) begin
          skid_q <= '0;
        end else if (load_skid) begin
          skid_q <= data_in;
        end
      end

      // Registered from the next state, cutting any out_ready -> in_ready path.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_d != PS_TWO);
        end
      end

      assign skid_data = skid_q;
      assign in_ready  = in_ready_q;
    end else begin : g_no_skid
      assign skid_data = '0;
      assign in_ready  = out_ready | ~out_valid;
    end
  endgenerate

  // Counts held-output cycles; flush leaves it alone, only reset clears it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

endmodule
